// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into a 32-bit instruction word
// and writes it into instruction memory at an auto-incrementing word address.
// One bundle is accepted in IDLE, the encoded word is presented in WRITE
// until the memory acknowledges it, then the address and count advance.

module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              flush,
  output logic              imemWrEn,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [31:0]       imemWrData,
  input  logic              imemAck,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              errIllegal
);

  // Opcodes the core's decoder recognises for each format class
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_SB = 7'b1100011;
  localparam logic [6:0] OP_U  = 7'b0110111;
  localparam logic [6:0] OP_UJ = 7'b1101111;

  // Format class codes on the fmt input
  localparam logic [2:0] FMT_I       = 3'd0;
  localparam logic [2:0] FMT_L       = 3'd1;
  localparam logic [2:0] FMT_R       = 3'd2;
  localparam logic [2:0] FMT_S       = 3'd3;
  localparam logic [2:0] FMT_SB      = 3'd4;
  localparam logic [2:0] FMT_U       = 3'd5;
  localparam logic [2:0] FMT_UJ      = 3'd6;
  localparam logic [2:0] FMT_ILLEGAL = 3'd7;

  // Count value at which the loader is considered full
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state;

  logic [31:0]     i_word;
  logic [31:0]     l_word;
  logic [31:0]     r_word;
  logic [31:0]     s_word;
  logic [31:0]     sb_word;
  logic [31:0]     u_word;
  logic [31:0]     uj_word;
  logic [31:0]     enc_word;
  logic [ADDR_W:0] count_inc;
  logic            accept;

  // Bit layouts of each format; immediates are byte offsets, so the branch
  // and jump forms drop imm[0] and scatter the remaining bits
  assign i_word  = {imm[11:0], rs1, funct3, rd, OP_I};
  assign l_word  = {imm[11:0], rs1, funct3, rd, OP_L};
  assign r_word  = {funct7, rs2, rs1, funct3, rd, OP_R};
  assign s_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
  assign sb_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_SB};
  assign u_word  = {imm[31:12], rd, OP_U};
  assign uj_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_UJ};

  // Select the layout for the incoming format class
  always_comb begin
    enc_word = 32'd0;
    case (fmt)
      FMT_I:   enc_word = i_word;
      FMT_L:   enc_word = l_word;
      FMT_R:   enc_word = r_word;
      FMT_S:   enc_word = s_word;
      FMT_SB:  enc_word = sb_word;
      FMT_U:   enc_word = u_word;
      FMT_UJ:  enc_word = uj_word;
      default: enc_word = 32'd0;
    endcase
  end

  // Flush takes priority over a same-cycle bundle, and nothing is taken
  // while a write is outstanding or the memory image is full
  assign inReady   = (state == IDLE) && !full && !flush;
  assign accept    = inValid && inReady;
  assign count_inc = count + 1'b1;

  // Handshake FSM: capture a bundle in IDLE, hold the write until acked
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      imemWrEn   <= 1'b0;
      imemAddr   <= '0;
      imemWrData <= 32'd0;
      count      <= '0;
      full       <= 1'b0;
      errIllegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            imemAddr   <= '0;
            count      <= '0;
            full       <= 1'b0;
            errIllegal <= 1'b0;
          end else if (accept) begin
            if (fmt == FMT_ILLEGAL) begin
              errIllegal <= 1'b1;
            end else begin
              imemWrData <= enc_word;
              imemWrEn   <= 1'b1;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          if (imemAck) begin
            imemAddr <= imemAddr + 1'b1;
            count    <= count_inc;
            full     <= (count_inc == DEPTH_CNT);
            imemWrEn <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          imemWrEn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for instr_encoder with a 4-word memory
// image. Expected writes go into a scoreboard queue when a bundle is issued;
// a monitor pops and compares whenever the encoder's write is acknowledged.

module tb_instr_encoder;

  localparam int ADDR_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } expWrite_t;

  logic              clk;
  logic              rstN;
  logic              inValid;
  logic              inReady;
  logic [2:0]        fmt;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              flush;
  logic              imemWrEn;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemWrData;
  logic              imemAck;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              errIllegal;

  expWrite_t         sbQueue[$];
  logic [ADDR_W-1:0] nextAddr;
  int                vectors;
  int                miscompares;
  int                writesSeen;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .inValid    (inValid),
    .inReady    (inReady),
    .fmt        (fmt),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .flush      (flush),
    .imemWrEn   (imemWrEn),
    .imemAddr   (imemAddr),
    .imemWrData (imemWrData),
    .imemAck    (imemAck),
    .count      (count),
    .full       (full),
    .errIllegal (errIllegal)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some handshake never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: every acknowledged write must match the oldest expectation
  always @(negedge clk) begin
    if (rstN && imemWrEn && imemAck) begin
      writesSeen++;
      vectors++;
      if (sbQueue.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL write_unexpected: actual addr=%0d data=%08h required=no write",
                 imemAddr, imemWrData);
      end else begin
        expWrite_t exp;
        exp = sbQueue.pop_front();
        if (imemAddr !== exp.addr || imemWrData !== exp.data) begin
          miscompares++;
          $display("[TB] FAIL write: actual addr=%0d data=%08h required addr=%0d data=%08h",
                   imemAddr, imemWrData, exp.addr, exp.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Offer one bundle; legal formats push their expected write first
  task automatic applyStimulus(input logic [2:0] f, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] im, input logic [31:0] expWord);
    bit accepted;
    accepted = 1'b0;
    @(negedge clk);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    inValid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (inReady) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: actual inReady=0 required=1");
      inValid = 1'b0;
    end else begin
      if (f != 3'd7) begin
        sbQueue.push_back('{addr: nextAddr, data: expWord});
        nextAddr = nextAddr + 1'b1;
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
    end
  endtask

  // Wait until the outstanding write has been retired
  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!imemWrEn) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL idle_timeout: actual imemWrEn=1 required=0");
    end
  endtask

  task automatic doFlush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    nextAddr = '0;
  endtask

  initial begin
    int writesBefore;
    vectors = 0; miscompares = 0; writesSeen = 0;
    nextAddr = '0;
    rstN = 1'b0; inValid = 1'b0; flush = 1'b0; imemAck = 1'b1;
    fmt = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0;
    imm = 32'd0;
    #22;
    rstN = 1'b1;

    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_wren", 32'(imemWrEn), 32'd0);
    checkOutput("rst_addr", 32'(imemAddr), 32'd0);
    checkOutput("rst_data", imemWrData, 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_err", 32'(errIllegal), 32'd0);
    checkOutput("rst_ready", 32'(inReady), 32'd1);

    $display("[TB] add x3,x1,x2 with ack tied high");
    applyStimulus(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
    checkOutput("add_latency_wren", 32'(imemWrEn), 32'd1);
    checkOutput("add_ready_low", 32'(inReady), 32'd0);
    waitIdle();
    checkOutput("add_count", 32'(count), 32'd1);

    $display("[TB] addi then beq back-to-back");
    applyStimulus(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093);
    checkOutput("addi_ready_low", 32'(inReady), 32'd0);
    applyStimulus(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h00208463);
    checkOutput("beq_ready_low", 32'(inReady), 32'd0);

    $display("[TB] jal fills the 4-word image");
    applyStimulus(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF);
    waitIdle();
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_addr_wrap", 32'(imemAddr), 32'd0);
    checkOutput("full_ready", 32'(inReady), 32'd0);

    $display("[TB] flush then illegal format");
    doFlush();
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_full", 32'(full), 32'd0);
    writesBefore = writesSeen;
    applyStimulus(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("illegal_err", 32'(errIllegal), 32'd1);
    checkOutput("illegal_no_wren", 32'(imemWrEn), 32'd0);
    checkOutput("illegal_count", 32'(count), 32'd0);
    @(negedge clk);
    checkOutput("illegal_no_write", 32'(writesSeen), 32'(writesBefore));

    $display("[TB] flush wins over same-cycle bundle");
    @(negedge clk);
    flush = 1'b1; inValid = 1'b1;
    fmt = 3'd2; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd0; funct7 = 7'd0;
    #1;
    checkOutput("flush_ready_low", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; inValid = 1'b0;
    checkOutput("flush_no_accept", 32'(imemWrEn), 32'd0);
    checkOutput("flush_clears_err", 32'(errIllegal), 32'd0);

    $display("[TB] lui, sw, lw");
    applyStimulus(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7);
    applyStimulus(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12, 32'h0020A623);
    applyStimulus(3'd1, 5'd4, 5'd1, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFFC0A203);
    waitIdle();
    checkOutput("three_count", 32'(count), 32'd3);

    $display("[TB] back-pressure on sub x5,x6,x7");
    imemAck = 1'b0;
    applyStimulus(3'd2, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0, 32'h407302B3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_wren", 32'(imemWrEn), 32'd1);
      checkOutput("bp_addr", 32'(imemAddr), 32'd3);
      checkOutput("bp_data", imemWrData, 32'h407302B3);
      checkOutput("bp_ready", 32'(inReady), 32'd0);
    end
    @(posedge clk);
    #1;
    imemAck = 1'b1;
    @(posedge clk);
    #1;
    imemAck = 1'b0;
    checkOutput("bp_addr_after", 32'(imemAddr), 32'd0);
    checkOutput("bp_count_after", 32'(count), 32'd4);
    checkOutput("bp_wren_after", 32'(imemWrEn), 32'd0);

    $display("[TB] bne with negative offset after flush");
    imemAck = 1'b1;
    doFlush();
    applyStimulus(3'd4, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFFFFFC, 32'hFE209EE3);
    waitIdle();

    $display("[TB] async reset during write");
    imemAck = 1'b0;
    applyStimulus(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
    @(negedge clk);
    checkOutput("pre_rst_wren", 32'(imemWrEn), 32'd1);
    checkOutput("pre_rst_addr", 32'(imemAddr), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_wren", 32'(imemWrEn), 32'd0);
    checkOutput("async_rst_addr", 32'(imemAddr), 32'd0);
    checkOutput("async_rst_count", 32'(count), 32'd0);
    sbQueue.delete();
    nextAddr = '0;
    @(negedge clk);
    rstN = 1'b1;
    imemAck = 1'b1;
    applyStimulus(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7);
    waitIdle();
    checkOutput("post_rst_count", 32'(count), 32'd1);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder: the inverse of the control/decode path.
- Accepts decoded fields (format class, register indices, funct codes, immediate) over a valid/ready handshake.
- Packs them into a 32-bit instruction word using the opcodes the core decodes.
- Writes each word into instruction memory at an auto-incrementing address.
- Used for self-test program loading and for bench stimulus generation.

Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 2**ADDR_W: number of words the loader may write before asserting full.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- inValid  input  1  field bundle valid.
- inReady  output  1  encoder can accept a bundle.
- fmt  input  3  format: 0=I (0010011), 1=L (0000011), 2=R (0110011), 3=S (0100011), 4=SB (1100011), 5=U (0110111), 6=UJ (1101111), 7=illegal.
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field (R only).
- imm  input  32  immediate, byte offset / full value.
- flush  input  1  clear address, count, full, error.
- imemWrEn  output  1  memory write request.
- imemAddr  output  ADDR_W  word address.
- imemWrData  output  32  encoded instruction.
- imemAck  input  1  memory accepted the write this cycle.
- count  output  ADDR_W+1  words written since reset/flush.
- full  output  1  count == DEPTH.
- errIllegal  output  1  sticky: an fmt=7 bundle was received.

Behaviour:
- Reset (rstN low, async): state IDLE, imemWrEn=0, imemAddr=0, imemWrData=0, count=0, full=0, errIllegal=0.
- Encoding per format:
  - I/L: imm[11:0], rs1, funct3, rd, opcode.
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - SB: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - UJ: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - Unused imm bits are ignored; no range checking is done.
- FSM states: IDLE, WRITE.
- inReady = (state==IDLE) && !full && !flush.
- IDLE:
  - Transfer occurs when inValid && inReady. The encoded word is registered into imemWrData.
  - fmt≠7: go to WRITE. imemWrEn is high from the next cycle, so latency is 1 cycle.
  - fmt=7: set errIllegal, stay in IDLE. Nothing is written; address and count are unchanged.
- WRITE:
  - imemWrEn=1; imemAddr and imemWrData are held stable until imemAck.
  - On imemAck: imemAddr increments (wraps modulo 2**ADDR_W), count increments, return to IDLE with imemWrEn=0 on the next cycle.
  - imemAck is permitted in the same cycle imemWrEn first rises. Maximum throughput is therefore one word per 2 cycles.
  - imemAck is ignored while in IDLE.
- full:
  - Set on the ack that makes count==DEPTH.
  - While full, inReady=0. imemAddr has wrapped to 0 but no write occurs.
- flush:
  - Honoured only in IDLE: clears imemAddr, count, full and errIllegal next cycle.
  - flush with inValid in the same cycle: flush wins and the bundle is not accepted (inReady low).
  - flush in WRITE is ignored; the write completes normally.
- Reset asserted mid-WRITE: imemWrEn drops immediately (async). The pending word is lost.
- errIllegal clears only on reset or flush.

Test Plan:
- R-type add x3,x1,x2 (fmt=2, rd=3, rs1=1, rs2=2, funct3=0, funct7=0), imemAck tied high -> imemWrEn high 1 cycle later, imemAddr=0, imemWrData=0x002081B3; count=1.
- I-type addi x1,x0,5 then SB beq x1,x2,+8 (imm=8) back-to-back -> words 0x00500093 at addr 0 and 0x00208463 at addr 1; inReady low during each WRITE cycle.
- UJ jal x1,+2048 (imm=0x800) -> 0x001000EF; U lui x5,0x12345000 -> 0x123452B7.
- Back-pressure: hold imemAck low 3 cycles in WRITE -> imemWrEn, imemAddr and imemWrData stable for all 3 cycles, inReady=0; ack on 4th cycle -> addr increments once.
- ADDR_W=2: write 4 words -> full=1, count=4, imemAddr=0, inReady=0. Then send fmt=7 after a flush -> errIllegal=1, no imemWrEn, count=0.
- Assert rstN low while imemWrEn=1 with no ack -> imemWrEn, imemAddr and count go to 0 without waiting for a clock edge; first bundle after release writes to addr 0.
